// File: rtl/sw_pkg.sv
// Shared types and defaults for the Smith-Waterman sequence loader and its storage.
package sw_pkg;

    typedef enum logic [1:0] {
        SYM_A = 2'd0,
        SYM_C = 2'd1,
        SYM_G = 2'd2,
        SYM_T = 2'd3
    } sym_t;

    localparam int LEN_REF_DEF   = 64;
    localparam int LEN_QUERY_DEF = 48;
    localparam int PE_NUM_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/sw_sym_ram.sv
// Symbol register file: rows of LANES 2-bit symbols, one lane-granular write port,
// one registered full-row read port. Rows at or beyond DEPTH read back as zero.
module sw_sym_ram #(
    parameter int DEPTH = 64,
    parameter int LANES = 1,
    parameter int AW    = 6,
    parameter int LW    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [LW-1:0]        wlane_i,
    input  logic [1:0]           wdata_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [2*LANES-1:0]   rdata_o
);

    logic [2*LANES-1:0] mem_q [DEPTH];
    logic [2*LANES-1:0] rdata_q;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i][2*int'(wlane_i) +: 2] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sw_seq_loader.sv
// Smith-Waterman input stage: captures a serial ref/query job, serves the PE array in HOLD.
// Optional sticky error flag output `err` is built when SW_SEQ_LOADER_ERR_EN is defined.
module sw_seq_loader
    import sw_pkg::*;
#(
    parameter int LEN_REF       = LEN_REF_DEF,
    parameter int LEN_QUERY     = LEN_QUERY_DEF,
    parameter int PE_NUM        = PE_NUM_DEF,
    parameter int WIDTH_IDX_REF = 6,
    parameter int WIDTH_GRP_Q   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [1:0]               data_ref,
    input  logic [1:0]               data_query,
    output logic                     load_done,
    input  logic                     rd_en,
    input  logic [WIDTH_IDX_REF-1:0] rd_ref_idx,
    input  logic [WIDTH_GRP_Q-1:0]   rd_q_grp,
    output logic                     rd_valid,
    output logic [1:0]               ref_sym,
    output logic [2*PE_NUM-1:0]      q_syms,
    output logic [PE_NUM-1:0]        q_mask,
    input  logic                     release_i,
`ifdef SW_SEQ_LOADER_ERR_EN
    output logic                     err,
`endif
    output state_t                   state_dbg_o
);

    localparam int NUM_GRP = ceil_div(LEN_QUERY, PE_NUM);
    localparam int RCNT_W  = WIDTH_IDX_REF + 1;
    localparam int QCNT_W  = $clog2(LEN_QUERY + 1);
    localparam int LANE_W  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

    state_t                 state_q;
    logic [RCNT_W-1:0]      ref_cnt_q;
    logic [QCNT_W-1:0]      q_cnt_q;
    logic [WIDTH_GRP_Q-1:0] q_row_q;
    logic [LANE_W-1:0]      q_lane_q;
    logic                   load_done_q;
    logic                   rd_valid_q;
    logic                   ref_oob_q;
    logic [PE_NUM-1:0]      q_mask_q;

    logic                   accept;
    logic                   q_take;
    logic                   last_ref;
    logic                   rd_fire;
    logic                   rel_fire;
    logic                   ref_oob_d;
    logic                   grp_oob_d;
    logic [PE_NUM-1:0]      q_mask_d;

    logic [1:0]             ref_rdata;
    logic [2*PE_NUM-1:0]    q_rdata;

    // IDLE and LOAD accept symbols identically; counters are zero in IDLE.
    always_comb begin
        accept    = valid && (state_q != ST_HOLD);
        q_take    = accept && (q_cnt_q < QCNT_W'(LEN_QUERY));
        last_ref  = (ref_cnt_q == RCNT_W'(LEN_REF - 1));
        rd_fire   = rd_en && (state_q == ST_HOLD);
        rel_fire  = release_i && (state_q == ST_HOLD);
        ref_oob_d = (int'(rd_ref_idx) >= LEN_REF);
        grp_oob_d = (int'(rd_q_grp) >= NUM_GRP);
        q_mask_d  = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            q_mask_d[k] = ((int'(rd_q_grp) * PE_NUM + k) < LEN_QUERY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ref_cnt_q   <= '0;
            q_cnt_q     <= '0;
            q_row_q     <= '0;
            q_lane_q    <= '0;
            load_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            ref_oob_q   <= 1'b0;
            q_mask_q    <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                ref_oob_q <= ref_oob_d;
                q_mask_q  <= q_mask_d;
            end
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        ref_cnt_q   <= ref_cnt_q + 1'b1;
                        state_q     <= last_ref ? ST_HOLD : ST_LOAD;
                        load_done_q <= last_ref;
                        if (q_take) begin
                            q_cnt_q <= q_cnt_q + 1'b1;
                            if (q_lane_q == LANE_W'(PE_NUM - 1)) begin
                                q_lane_q <= '0;
                                q_row_q  <= q_row_q + 1'b1;
                            end else begin
                                q_lane_q <= q_lane_q + 1'b1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (rel_fire) begin
                        state_q     <= ST_IDLE;
                        ref_cnt_q   <= '0;
                        q_cnt_q     <= '0;
                        q_row_q     <= '0;
                        q_lane_q    <= '0;
                        load_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sw_sym_ram #(
        .DEPTH (LEN_REF),
        .LANES (1),
        .AW    (WIDTH_IDX_REF),
        .LW    (1)
    ) u_ref_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (accept),
        .waddr_i (ref_cnt_q[WIDTH_IDX_REF-1:0]),
        .wlane_i (1'b0),
        .wdata_i (data_ref),
        .re_i    (rd_fire),
        .raddr_i (rd_ref_idx),
        .rdata_o (ref_rdata)
    );

    sw_sym_ram #(
        .DEPTH (NUM_GRP),
        .LANES (PE_NUM),
        .AW    (WIDTH_GRP_Q),
        .LW    (LANE_W)
    ) u_q_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (q_take),
        .waddr_i (q_row_q),
        .wlane_i (q_lane_q),
        .wdata_i (data_query),
        .re_i    (rd_fire),
        .raddr_i (rd_q_grp),
        .rdata_o (q_rdata)
    );

    // Lanes past the query tail were never written, so they are forced to zero.
    always_comb begin
        ref_sym = ref_oob_q ? 2'b00 : ref_rdata;
        q_syms  = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            q_syms[2*k +: 2] = q_mask_q[k] ? q_rdata[2*k +: 2] : 2'b00;
        end
    end

    assign load_done   = load_done_q;
    assign rd_valid    = rd_valid_q;
    assign q_mask      = q_mask_q;
    assign state_dbg_o = state_q;

`ifdef SW_SEQ_LOADER_ERR_EN
    logic err_q;
    logic err_set;

    always_comb begin
        err_set = (valid && (state_q == ST_HOLD))
               || (rd_en && (state_q != ST_HOLD))
               || (rd_fire && (ref_oob_d || grp_oob_d));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (rel_fire) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_oob;
    assign unused_oob = grp_oob_d;
`endif

endmodule
